// File: rtl/x1_irq_daisy_ctrl_if.sv
// Bus bundle between the X1 interrupt daisy-chain controller and its surroundings:
// peripheral request/vector lines, the CPU control strobes it snoops, and the
// vector/ack/in-service outputs it drives back.
interface x1_irq_daisy_ctrl_if #(
   parameter int NSRC = 4
);
   logic                cep;
   logic [NSRC-1:0]     irq_req;
   logic [8*NSRC-1:0]   irq_vec;
   logic                m1_n;
   logic                mreq_n;
   logic                iorq_n;
   logic                rd_n;
   logic [7:0]          cpu_di;
   logic                int_n;
   logic [7:0]          vec_out;
   logic                vec_oe;
   logic [NSRC-1:0]     irq_ack;
   logic [NSRC-1:0]     in_service;

   // Controller side: consumes requests and CPU strobes, produces int/vector/ack
   modport slave (
      input  cep, irq_req, irq_vec, m1_n, mreq_n, iorq_n, rd_n, cpu_di,
      output int_n, vec_out, vec_oe, irq_ack, in_service
   );

   // Environment side: CPU wrapper plus peripherals
   modport master (
      output cep, irq_req, irq_vec, m1_n, mreq_n, iorq_n, rd_n, cpu_di,
      input  int_n, vec_out, vec_oe, irq_ack, in_service
   );
endinterface

// File: rtl/x1_irq_daisy_ctrl.sv
// Z80 mode-2 interrupt daisy-chain emulation for the X1 core.
// Fixed-priority arbitration (index 0 highest), registered int_n, vector
// delivery during INTA, and RETI (ED 4D) snooping to retire in-service levels.
module x1_irq_daisy_ctrl #(
   parameter int          NSRC         = 4,
   parameter logic [7:0]  SPURIOUS_VEC = 8'hFF
) (
   input  logic                 clock,
   input  logic                 reset_n,
   x1_irq_daisy_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      HOLD = 2'd2
   } StateT;

   StateT            r_state;
   StateT            w_stateNext;

   logic             r_intN;
   logic [7:0]       r_vecOut;
   logic             r_vecOe;
   logic [NSRC-1:0]  r_irqAck;
   logic [NSRC-1:0]  r_inService;
   logic             r_prevEd;
   logic             r_inFetch;
   logic [7:0]       r_opcode;

   logic [NSRC-1:0]  w_elig;
   logic             w_anyElig;
   logic [NSRC-1:0]  w_winOneHot;
   logic [7:0]       w_winVec;
   logic [NSRC-1:0]  w_isClear;
   logic [NSRC-1:0]  w_isSet;
   logic [NSRC-1:0]  w_isNext;
   logic [NSRC-1:0]  w_ackNext;
   logic [7:0]       w_vecOutNext;
   logic             w_vecOeNext;
   logic             w_inta;
   logic             w_fetch;
   logic             w_commit;
   logic             w_reti;

   assign w_inta   = ~bus.m1_n & ~bus.iorq_n;
   assign w_fetch  = ~bus.m1_n & ~bus.mreq_n & ~bus.rd_n & bus.iorq_n;
   assign w_commit = r_inFetch & bus.m1_n;
   assign w_reti   = w_commit & r_prevEd & (r_opcode == 8'h4D);

   // A request is eligible only if no level of equal or higher priority is in service
   always_comb begin
      logic masked;
      masked = 1'b0;
      w_elig = '0;
      for (int i = 0; i < NSRC; i++) begin
         masked    = masked | r_inService[i];
         w_elig[i] = bus.irq_req[i] & ~masked;
      end
   end

   assign w_anyElig = |w_elig;

   // Pick the lowest eligible index and its vector; nothing eligible yields the spurious vector
   always_comb begin
      logic found;
      found       = 1'b0;
      w_winOneHot = '0;
      w_winVec    = SPURIOUS_VEC;
      for (int i = 0; i < NSRC; i++) begin
         if (w_elig[i] && !found) begin
            found          = 1'b1;
            w_winOneHot[i] = 1'b1;
            w_winVec       = bus.irq_vec[8*i +: 8];
         end
      end
   end

   // A committed RETI retires the highest-priority (lowest-index) in-service level
   always_comb begin
      logic found;
      found     = 1'b0;
      w_isClear = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (w_reti && r_inService[i] && !found) begin
            found        = 1'b1;
            w_isClear[i] = 1'b1;
         end
      end
   end

   // Clear from RETI is applied before the INTA set so a newly granted level always survives
   assign w_isNext = (r_inService & ~w_isClear) | w_isSet;

   // Acknowledge FSM next-state and next output values
   always_comb begin
      w_stateNext  = r_state;
      w_ackNext    = '0;
      w_isSet      = '0;
      w_vecOutNext = r_vecOut;
      w_vecOeNext  = r_vecOe;
      case (r_state)
         IDLE: begin
            if (w_inta) begin
               w_stateNext  = ACK;
               w_vecOutNext = w_winVec;
               w_vecOeNext  = 1'b1;
               w_ackNext    = w_winOneHot;
               w_isSet      = w_winOneHot;
            end
         end
         ACK: begin
            w_stateNext = HOLD;
            w_vecOeNext = 1'b1;
         end
         HOLD: begin
            if (bus.iorq_n) begin
               w_stateNext = IDLE;
               w_vecOeNext = 1'b0;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_vecOeNext = 1'b0;
         end
      endcase
   end

   // FSM state register, advancing only on CPU clock-enable edges
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else if (bus.cep) begin
         r_state <= w_stateNext;
      end
   end

   // Registered interrupt line, vector, ack pulse and in-service flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_intN      <= 1'b1;
         r_vecOut    <= 8'hFF;
         r_vecOe     <= 1'b0;
         r_irqAck    <= '0;
         r_inService <= '0;
      end else if (bus.cep) begin
         r_intN      <= ~w_anyElig;
         r_vecOut    <= w_vecOutNext;
         r_vecOe     <= w_vecOeNext;
         r_irqAck    <= w_ackNext;
         r_inService <= w_isNext;
      end
   end

   // Opcode snoop: capture the byte during a fetch, commit it when M1 goes high
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_inFetch <= 1'b0;
         r_opcode  <= 8'h00;
         r_prevEd  <= 1'b0;
      end else if (bus.cep) begin
         if (w_fetch) begin
            r_inFetch <= 1'b1;
            r_opcode  <= bus.cpu_di;
         end else if (w_commit) begin
            r_inFetch <= 1'b0;
            r_prevEd  <= (r_opcode == 8'hED);
         end
      end
   end

   assign bus.int_n      = r_intN;
   assign bus.vec_out    = r_vecOut;
   assign bus.vec_oe     = r_vecOe;
   assign bus.irq_ack    = r_irqAck;
   assign bus.in_service = r_inService;

endmodule
